// File: rtl/speles_kontrolieris.sv
// Round controller for the binary guessing game: LFSR target, per-guess timeout, score and round sequencing.
// Guess to hit/miss is 2 cycles, timer expiry to miss is 1 cycle; start is honoured only in IDLE and DONE.
module speles_kontrolieris #(
  parameter int unsigned ROUNDS      = 8,
  parameter int unsigned ROUND_TICKS = 50000000,
  parameter logic [3:0]  LFSR_SEED   = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       guess_valid,
  input  logic       match,
  output logic [3:0] target,
  output logic       target_valid,
  output logic       hit,
  output logic       miss,
  output logic       timeout,
  output logic [3:0] score,
  output logic [3:0] round_num,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_GUESS,
    S_CHECK,
    S_RESULT,
    S_DONE
  } state_t;

  localparam int unsigned TW         = $clog2(ROUND_TICKS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ROUND_TICKS - 1);
  localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [3:0]  SEED       = (LFSR_SEED == 4'd0) ? 4'd1 : LFSR_SEED;

  state_t        state_q, state_d;
  logic [3:0]    lfsr_q, lfsr_d;
  logic [3:0]    target_q, target_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    score_q, score_d;
  logic [3:0]    round_q, round_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      target_q  <= 4'd0;
      timer_q   <= '0;
      score_q   <= 4'd0;
      round_q   <= 4'd0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      score_q   <= score_d;
      round_q   <= round_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    target_d  = target_q;
    timer_d   = timer_q;
    score_d   = score_q;
    round_d   = round_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d = 4'd0;
          round_d = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        target_d = lfsr_q;
        lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        timer_d  = '0;
        state_d  = S_WAIT_GUESS;
      end
      S_WAIT_GUESS: begin
        timer_d = timer_q + 1'b1;
        // A guess landing on the expiry cycle takes priority over the timeout.
        if (guess_valid) begin
          state_d = S_CHECK;
        end else if (timer_q == TIMER_LAST) begin
          miss_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_RESULT;
        end
      end
      S_CHECK: begin
        if (match) begin
          hit_d = 1'b1;
          if (score_q != 4'hF) begin
            score_d = score_q + 4'd1;
          end
        end else begin
          miss_d = 1'b1;
        end
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (round_q == LAST_ROUND) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign target       = target_q;
  assign target_valid = (state_q == S_WAIT_GUESS);
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign timeout      = timeout_q;
  assign score        = score_q;
  assign round_num    = round_q;
  assign game_over    = (state_q == S_DONE);

endmodule

// File: tb/tb_speles_kontrolieris.sv
// Randomised bench for speles_kontrolieris: targets come from a table built from the LFSR rule,
// score/round expectations from simple per-round bookkeeping.
module tb_speles_kontrolieris;

  localparam int ROUNDS = 3;
  localparam int TICKS  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       guess_valid = 1'b0;
  logic       match = 1'b0;
  logic [3:0] target;
  logic       target_valid;
  logic       hit;
  logic       miss;
  logic       timeout;
  logic [3:0] score;
  logic [3:0] round_num;
  logic       game_over;

  speles_kontrolieris #(
    .ROUNDS(ROUNDS),
    .ROUND_TICKS(TICKS),
    .LFSR_SEED(4'b1001)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .guess_valid(guess_valid),
    .match(match),
    .target(target),
    .target_valid(target_valid),
    .hit(hit),
    .miss(miss),
    .timeout(timeout),
    .score(score),
    .round_num(round_num),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [3:0] tq[15];
  int         k = 0;
  logic [3:0] exp_score = 4'd0;
  logic [3:0] exp_round = 4'd0;

  // Target sequence for the seed, from the shift/feedback rule.
  function automatic void build_targets();
    logic [3:0] v;
    v = 4'b1001;
    for (int i = 0; i < 15; i++) begin
      tq[i] = v;
      v = {v[2:0], v[3] ^ v[2]};
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({target, target_valid, hit, miss, timeout, score, round_num, game_over} !== 17'd0)
      begin bad++; $display("FAIL reset_outputs: got %h want 0",
        {target, target_valid, hit, miss, timeout, score, round_num, game_over}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({target_valid, game_over, hit, miss} !== 4'b0)
      begin bad++; $display("FAIL idle_after_reset: got %b want 0000",
        {target_valid, game_over, hit, miss}); end
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = 4'd0;
    exp_round = 4'd0;
    total++;
    if ({target_valid, game_over, score, round_num} !== 10'd0)
      begin bad++; $display("FAIL start_load: tv=%b go=%b score=%0d round=%0d want all 0",
        target_valid, game_over, score, round_num); end
  endtask

  // Entered with the DUT in LOAD; returns with it in LOAD (next round) or DONE.
  task automatic play_round(input int d, input bit want_hit, input bit to, input bit noise);
    logic [3:0] exp_tgt;
    logic [3:0] sw;
    int         cnt;
    bit         last;
    bit         got_hit;
    exp_tgt = tq[k % 15];
    k++;
    tick();
    total++;
    if (target_valid !== 1'b1 || target !== exp_tgt)
      begin bad++; $display("FAIL round_entry: tv=%b target=%0d want tv=1 target=%0d",
        target_valid, target, exp_tgt); end
    if (to) begin
      cnt = 0;
      for (int i = 0; i < 4 * TICKS && target_valid === 1'b1; i++) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cnt++;
        tick();
      end
      start = 1'b0;
      total++;
      if (cnt !== TICKS)
        begin bad++; $display("FAIL tv_cycles: got %0d want %0d", cnt, TICKS); end
      total++;
      if ({hit, miss, timeout} !== 3'b011)
        begin bad++; $display("FAIL timeout_pulses: hit/miss/to=%b want 011", {hit, miss, timeout}); end
      got_hit = 1'b0;
    end else begin
      for (int i = 0; i < d; i++) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        match = 1'($urandom_range(0, 1));
        tick();
        total++;
        if (target_valid !== 1'b1)
          begin bad++; $display("FAIL wait_tv: cycle %0d tv=%b want 1", i, target_valid); end
      end
      start = 1'b0;
      sw = want_hit ? exp_tgt : (exp_tgt ^ 4'($urandom_range(1, 15)));
      guess_valid = 1'b1;
      match = ~want_hit;
      tick();
      guess_valid = 1'b0;
      match = (sw == exp_tgt);
      total++;
      if ({target_valid, hit, miss, timeout} !== 4'b0)
        begin bad++; $display("FAIL check_cycle: tv/hit/miss/to=%b want 0000",
          {target_valid, hit, miss, timeout}); end
      tick();
      total++;
      if ({hit, miss, timeout} !== {want_hit, ~want_hit, 1'b0})
        begin bad++; $display("FAIL result_pulses: hit/miss/to=%b want %b",
          {hit, miss, timeout}, {want_hit, ~want_hit, 1'b0}); end
      got_hit = want_hit;
    end
    match = 1'b0;
    if (got_hit && exp_score != 4'd15) exp_score = exp_score + 4'd1;
    total++;
    if (score !== exp_score)
      begin bad++; $display("FAIL score: got %0d want %0d", score, exp_score); end
    last = (int'(exp_round) == ROUNDS - 1);
    tick();
    if (!last) exp_round = exp_round + 4'd1;
    total++;
    if ({hit, miss, timeout} !== 3'b0 || round_num !== exp_round || game_over !== last ||
        score !== exp_score)
      begin bad++; $display("FAIL after_result: pulses=%b round=%0d go=%b score=%0d want 000 %0d %b %0d",
        {hit, miss, timeout}, round_num, game_over, score, exp_round, last, exp_score); end
  endtask

  task automatic test_first_game();
    start_game();
    play_round($urandom_range(0, TICKS - 2), 1'b1, 1'b0, 1'b0);
    play_round(0, 1'b0, 1'b1, 1'b0);
    play_round(TICKS - 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_done_hold();
    logic [3:0] held_tgt;
    held_tgt = tq[(k - 1) % 15];
    for (int i = 0; i < 5; i++) begin
      guess_valid = 1'($urandom_range(0, 1));
      match = 1'b1;
      tick();
      total++;
      if (game_over !== 1'b1 || target_valid !== 1'b0 || score !== exp_score ||
          round_num !== 4'(ROUNDS - 1) || target !== held_tgt || hit !== 1'b0 || miss !== 1'b0)
        begin bad++; $display("FAIL done_hold: go=%b tv=%b score=%0d round=%0d target=%0d want 1 0 %0d %0d %0d",
          game_over, target_valid, score, round_num, target, exp_score, ROUNDS - 1, held_tgt); end
    end
    guess_valid = 1'b0;
    match = 1'b0;
  endtask

  task automatic test_all_hits();
    start_game();
    for (int r = 0; r < ROUNDS; r++)
      play_round($urandom_range(0, TICKS - 1), 1'b1, 1'b0, 1'b1);
    total++;
    if (score !== 4'd3 || round_num !== 4'd2 || game_over !== 1'b1)
      begin bad++; $display("FAIL all_hits: score=%0d round=%0d go=%b want 3 2 1",
        score, round_num, game_over); end
  endtask

  task automatic test_random_games(input int n);
    for (int g = 0; g < n; g++) begin
      start_game();
      for (int r = 0; r < ROUNDS; r++)
        play_round($urandom_range(0, TICKS - 1), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), 1'b1);
      test_done_hold();
    end
  endtask

  task automatic test_reset_mid_round();
    start_game();
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({target, target_valid, hit, miss, timeout, score, round_num, game_over} !== 17'd0)
      begin bad++; $display("FAIL reset_mid_round: got %h want 0",
        {target, target_valid, hit, miss, timeout, score, round_num, game_over}); end
    tick();
    total++;
    if ({hit, miss, timeout, target_valid} !== 4'b0)
      begin bad++; $display("FAIL reset_no_pulse: got %b want 0000",
        {hit, miss, timeout, target_valid}); end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    tick();
    start_game();
    play_round($urandom_range(0, TICKS - 1), 1'b1, 1'b0, 1'b0);
    total++;
    if (tq[0] !== 4'd9)
      begin bad++; $display("FAIL seed_table: got %0d want 9", tq[0]); end
  endtask

  initial begin
    build_targets();
    test_reset();
    test_first_game();
    test_done_hold();
    test_all_hits();
    test_done_hold();
    test_random_games(4);
    test_reset_mid_round();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speles_kontrolieris.md
Name: speles_kontrolieris

Overview:
Round controller for the binary number game: the producer side of the guess comparator. It generates a 4-bit target from an LFSR, drives it onto the comparator's num_1 input, and samples the comparator's match result when the player commits a guess. It also runs the per-round timeout, keeps the score, and sequences a fixed number of rounds per game. It sits between the switch/button debouncers and the comparator/LED display logic.

Parameters:
ROUNDS, 8, rounds per game (1..15)
ROUND_TICKS, 50000000, clock cycles allowed per guess before timeout (>=2)
LFSR_SEED, 4'b1001, LFSR reset value; a seed of 0 is forced to 4'b0001

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse (debounced); starts a game
guess_valid  in  1  single-cycle pulse; player commits the current switch value
match  in  1  comparator result (target == switches), combinational, valid in the cycle after guess_valid
target  out  4  current target; drives comparator num_1
target_valid  out  1  high while waiting for a guess
hit  out  1  one-cycle pulse: guess correct
miss  out  1  one-cycle pulse: guess wrong or timed out
timeout  out  1  one-cycle pulse, coincident with miss, on timer expiry
score  out  4  correct guesses this game, saturates at 15
round_num  out  4  current round index, 0-based
game_over  out  1  high in DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; target=0, target_valid=0, hit=miss=timeout=0, score=0, round_num=0, game_over=0, timer=0, lfsr=LFSR_SEED (0 becomes 1). Reset mid-round abandons the game with no pulses.
- LFSR: 4-bit, next = {lfsr[2:0], lfsr[3]^lfsr[2]}, period 15, never 0. Advances only in LOAD, so targets are deterministic per seed and lie in 1..15.
- States: IDLE, LOAD, WAIT_GUESS, CHECK, RESULT, DONE.
- IDLE: start -> LOAD; score and round_num cleared.
- LOAD (1 cycle): target<=lfsr, lfsr<=next, timer<=0 -> WAIT_GUESS.
- WAIT_GUESS: target_valid=1; timer increments each cycle.
  - guess_valid -> CHECK.
  - Otherwise, timer==ROUND_TICKS-1 -> RESULT with miss=1 and timeout=1.
  - guess_valid in the same cycle as expiry: the guess wins and no timeout is raised.
- CHECK (1 cycle, target_valid=0): sample match.
  - match=1: hit pulse; score+1, saturating at 15.
  - match=0: miss pulse.
  - Either way -> RESULT.
- Pulses are registered: hit/miss/timeout are high in the first RESULT cycle only.
- RESULT (1 cycle): if round_num==ROUNDS-1 -> DONE; else round_num+1 -> LOAD.
- DONE: game_over=1. score, round_num and target hold. start -> score=0, round_num=0, game_over=0 -> LOAD.
- start is ignored in LOAD/WAIT_GUESS/CHECK/RESULT. guess_valid is ignored outside WAIT_GUESS.
- Latency:
  - start to target_valid: 2 cycles.
  - guess_valid to hit/miss: 2 cycles.
  - timer expiry to miss: 1 cycle.

Test Plan:
- Reset then start with seed 1001 -> target=9 (target_valid two cycles later); after each round the next targets are 3, 6, 13, 10.
- Round 0, target=9, guess_valid with match=1 -> hit pulse 1 cycle wide, score=1, round_num=1, next target=3.
- ROUND_TICKS=10, no guess -> exactly 10 cycles of target_valid, then miss+timeout together for 1 cycle, score unchanged, round_num increments.
- guess_valid in the exact expiry cycle with match=1 -> hit=1, timeout=0, score increments.
- ROUNDS=3 with all hits -> game_over=1, score=3, round_num=2 held; start mid-game ignored; start in DONE -> score=0, next target continues the LFSR sequence.
- rst_n pulsed low while in WAIT_GUESS -> all outputs 0 immediately with no hit/miss; next game's first target=9 again.
